// File: rtl/temp_avg_bcd_if.sv
// ============================================================================
// temp_avg_bcd_if : sample input and BCD result bus of temp_avg_bcd
// Rev 1.0
// ============================================================================
`default_nettype none

interface temp_avg_bcd_if;
  logic        sample_valid_i;
  logic [12:0] temp_i;
  logic        sign_o;
  logic [11:0] bcd_o;
  logic [3:0]  frac_o;
  logic        valid_o;
  logic        alarm_o;
  logic        busy_o;
  logic        ovr_o;

  modport master (
    output sample_valid_i, temp_i,
    input  sign_o, bcd_o, frac_o, valid_o, alarm_o, busy_o, ovr_o
  );

  modport slave (
    input  sample_valid_i, temp_i,
    output sign_o, bcd_o, frac_o, valid_o, alarm_o, busy_o, ovr_o
  );
endinterface

`default_nettype wire

// File: rtl/temp_avg_bcd.sv
// ============================================================================
// temp_avg_bcd : moving-average temperature -> signed BCD with hysteresis alarm
// Rev 1.0
// ============================================================================
`default_nettype none

module temp_avg_bcd #(
  parameter int                 AVG_LOG2 = 2,
  parameter logic signed [12:0] HIGH_LIM = 13'sd480,
  parameter logic signed [12:0] LOW_LIM  = 13'sd448
) (
  input  logic           clk_i,
  input  logic           rst_i,
  temp_avg_bcd_if.slave  bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 13 + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    AVG   = 3'd2,
    CONV  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic signed [12:0]   sample_q;
  logic signed [12:0]   buf_q [DEPTH];
  logic signed [SW-1:0] sum_q;
  logic [PW-1:0]        ptr_q;
  logic                 first_q;
  logic                 neg_q;
  logic [3:0]           tenths_q;
  logic [20:0]          dd_q;
  logic [3:0]           cnt_q;
  logic                 sign_q;
  logic [11:0]          bcd_q;
  logic [3:0]           frac_q;
  logic                 valid_q;
  logic                 alarm_q;
  logic                 ovr_q;

  logic signed [SW-1:0] new_ext_w;
  logic signed [SW-1:0] old_ext_w;
  logic signed [SW-1:0] sum_sh_w;
  logic signed [12:0]   avg_w;
  logic [12:0]          mag_w;
  logic [7:0]           tenths_prod_w;
  logic [PW-1:0]        ptr_next_w;
  logic [20:0]          dd_adj_w;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int d = 0; d < 3; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign new_ext_w     = SW'(sample_q);
  assign old_ext_w     = SW'(buf_q[ptr_q]);
  assign sum_sh_w      = sum_q >>> AVG_LOG2;
  assign avg_w         = sum_sh_w[12:0];
  // -4096 negates to itself, which reads as 4096 when taken unsigned
  assign mag_w         = avg_w[12] ? 13'(-avg_w) : 13'(avg_w);
  assign tenths_prod_w = 8'(mag_w[3:0]) * 8'd10;
  assign ptr_next_w    = (32'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + 1'b1;
  assign dd_adj_w      = {add3(dd_q[20:9]), dd_q[8:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample_valid_i) state_d = ACCUM;
      ACCUM:   state_d = AVG;
      AVG:     state_d = CONV;
      CONV:    if (cnt_q == 4'd8) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample window; the first sample after reset fills every slot
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ACCUM) begin
      if (first_q) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= sample_q;
      end else begin
        buf_q[ptr_q] <= sample_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q <= '0;
      sum_q    <= '0;
      ptr_q    <= '0;
      first_q  <= 1'b1;
      neg_q    <= 1'b0;
      tenths_q <= '0;
      dd_q     <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      bcd_q    <= '0;
      frac_q   <= '0;
      valid_q  <= 1'b0;
      alarm_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.sample_valid_i && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.sample_valid_i) sample_q <= bus.temp_i;
        end
        ACCUM: begin
          if (first_q) begin
            sum_q   <= new_ext_w <<< AVG_LOG2;
            first_q <= 1'b0;
          end else begin
            sum_q <= sum_q - old_ext_w + new_ext_w;
            ptr_q <= ptr_next_w;
          end
        end
        AVG: begin
          neg_q    <= avg_w[12];
          tenths_q <= tenths_prod_w[7:4];
          dd_q     <= {12'd0, mag_w[12:4]};
          cnt_q    <= '0;
          if (avg_w >= HIGH_LIM)    alarm_q <= 1'b1;
          else if (avg_w < LOW_LIM) alarm_q <= 1'b0;
        end
        CONV: begin
          dd_q  <= {dd_adj_w[19:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
        end
        DONE: begin
          sign_q  <= neg_q;
          bcd_q   <= dd_q[20:9];
          frac_q  <= tenths_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sign_o  = sign_q;
  assign bus.bcd_o   = bcd_q;
  assign bus.frac_o  = frac_q;
  assign bus.valid_o = valid_q;
  assign bus.alarm_o = alarm_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.ovr_o   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_avg_bcd.sv
// ============================================================================
// tb_temp_avg_bcd : directed vectors against a window-average reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_temp_avg_bcd;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  temp_avg_bcd_if bus ();

  temp_avg_bcd dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state as of the most recent rising edge
  int         cyc = 0;
  bit         pend = 0;
  int         pk = 0;
  bit         first = 1;
  int         win[$];
  bit         m_alarm = 0;
  bit         p_sign, p_alarm;
  logic [11:0] p_bcd;
  logic [3:0]  p_frac;
  bit          e_sign = 0, e_valid = 0, e_alarm = 0, e_ovr = 0, e_busy = 0;
  logic [11:0] e_bcd = '0;
  logic [3:0]  e_frac = '0;

  always @(posedge clk) begin
    int t, s, avg, mag, ip;
    cyc++;
    e_valid = 0;
    if (rst) begin
      pend = 0; first = 1; win.delete(); m_alarm = 0;
      e_sign = 0; e_bcd = '0; e_frac = '0; e_alarm = 0; e_ovr = 0;
    end else begin
      if (pend && cyc == pk + 2) e_alarm = p_alarm;
      if (pend && cyc == pk + 12) begin
        e_sign = p_sign; e_bcd = p_bcd; e_frac = p_frac; e_valid = 1;
      end
      if (bus.sample_valid_i) begin
        if (pend && cyc <= pk + 12) e_ovr = 1;
        else begin
          t = int'($signed(bus.temp_i));
          if (first) begin
            win.delete();
            for (int i = 0; i < N; i++) win.push_back(t);
            first = 0;
          end else begin
            win.push_back(t);
            void'(win.pop_front());
          end
          s = 0;
          foreach (win[i]) s += win[i];
          avg = (s >= 0) ? s / N : -((-s + N - 1) / N);
          if (avg >= 480) m_alarm = 1;
          else if (avg < 448) m_alarm = 0;
          mag = (avg < 0) ? -avg : avg;
          ip = mag / 16;
          p_sign  = (avg < 0);
          p_bcd   = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
          p_frac  = 4'(((mag % 16) * 10) / 16);
          p_alarm = m_alarm;
          pk = cyc;
          pend = 1;
        end
      end
    end
    e_busy = pend && (cyc >= pk) && (cyc <= pk + 11);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic send(input logic [12:0] t);
    @(negedge clk); bus.sample_valid_i = 1'b1; bus.temp_i = t;
    @(negedge clk); bus.sample_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.valid_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", int'(bus.valid_o), 1);
  endtask

  task automatic expect_res(input string nm, input bit sg, input logic [11:0] b,
                            input logic [3:0] f);
    int n;
    wait_valid(n);
    check({nm, "_sign"}, int'(bus.sign_o), int'(sg));
    check({nm, "_bcd"},  int'(bus.bcd_o),  int'(b));
    check({nm, "_frac"}, int'(bus.frac_o), int'(f));
  endtask

  initial begin
    int n, cnt;
    bus.sample_valid_i = 1'b0;
    bus.temp_i = '0;
    do_reset();
    check("reset_outputs", int'({bus.sign_o, bus.bcd_o, bus.frac_o, bus.valid_o,
                                 bus.alarm_o, bus.busy_o, bus.ovr_o}), 0);

    fork
      forever begin
        @(negedge clk);
        check("cmp_valid", int'(bus.valid_o), int'(e_valid));
        check("cmp_busy",  int'(bus.busy_o),  int'(e_busy));
        check("cmp_ovr",   int'(bus.ovr_o),   int'(e_ovr));
        check("cmp_alarm", int'(bus.alarm_o), int'(e_alarm));
        check("cmp_sign",  int'(bus.sign_o),  int'(e_sign));
        check("cmp_bcd",   int'(bus.bcd_o),   int'(e_bcd));
        check("cmp_frac",  int'(bus.frac_o),  int'(e_frac));
      end
    join_none

    // 25.0 C with latency and busy window
    send(13'h0190);
    check("busy_first", int'(bus.busy_o), 1);
    wait_valid(n);
    check("latency", n, 12);
    check("r25_bcd", int'(bus.bcd_o), 12'h025);
    check("r25_frac_sign_alarm", int'({bus.frac_o, bus.sign_o, bus.alarm_o}), 0);
    check("busy_at_valid", int'(bus.busy_o), 0);

    do_reset();
    send(13'h1FF8);
    expect_res("neg_half", 1'b1, 12'h000, 4'd5);
    do_reset();
    send(13'h1000);
    expect_res("most_neg", 1'b1, 12'h256, 4'd0);

    // Averaging: prefill 400, then 480s
    do_reset();
    send(13'd400);
    expect_res("pre400", 1'b0, 12'h025, 4'd0);
    send(13'd480);
    expect_res("avg420", 1'b0, 12'h026, 4'd2);
    check("avg420_alarm", int'(bus.alarm_o), 0);
    repeat (3) begin send(13'd480); wait_valid(n); end
    check("avg480_bcd", int'(bus.bcd_o), 12'h030);
    check("avg480_frac", int'(bus.frac_o), 0);
    check("avg480_alarm", int'(bus.alarm_o), 1);

    // Hysteresis
    do_reset();
    send(13'd496);
    expect_res("pre496", 1'b0, 12'h031, 4'd0);
    check("alarm496", int'(bus.alarm_o), 1);
    repeat (4) begin send(13'd464); wait_valid(n); end
    check("alarm464", int'(bus.alarm_o), 1);
    send(13'd432); wait_valid(n);
    check("alarm456", int'(bus.alarm_o), 1);
    send(13'd432); wait_valid(n);
    check("alarm448", int'(bus.alarm_o), 1);
    send(13'd432);
    expect_res("avg440", 1'b0, 12'h027, 4'd5);
    check("alarm440", int'(bus.alarm_o), 0);

    // Drop during conversion: second sample five edges later
    do_reset();
    @(negedge clk); bus.sample_valid_i = 1'b1; bus.temp_i = 13'd160;
    @(negedge clk); bus.sample_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.sample_valid_i = 1'b1; bus.temp_i = 13'd800;
    @(negedge clk); bus.sample_valid_i = 1'b0;
    check("ovr_set", int'(bus.ovr_o), 1);
    wait_valid(n);
    check("drop_latency", n, 7);
    check("drop_bcd", int'(bus.bcd_o), 12'h010);
    send(13'd160);
    expect_res("drop_buf", 1'b0, 12'h010, 4'd0);
    check("ovr_sticky", int'(bus.ovr_o), 1);

    // Held-high sample_valid: one conversion, the rest dropped
    do_reset();
    @(negedge clk); bus.sample_valid_i = 1'b1; bus.temp_i = 13'd320;
    repeat (3) @(negedge clk);
    bus.sample_valid_i = 1'b0;
    expect_res("held", 1'b0, 12'h020, 4'd0);
    check("held_ovr", int'(bus.ovr_o), 1);

    // Reset mid-conversion, then prefill check
    do_reset();
    send(13'd400);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_outputs", int'({bus.sign_o, bus.bcd_o, bus.frac_o, bus.valid_o,
                                  bus.alarm_o, bus.busy_o, bus.ovr_o}), 0);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bus.valid_o) cnt++; end
    check("midrst_no_valid", cnt, 0);
    send(13'h0050);
    expect_res("midrst_prefill", 1'b0, 12'h005, 4'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/temp_avg_bcd.md
TEMP_AVG_BCD -- requirements
Module: temp_avg_bcd

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, log2 of moving-average depth (legal 0..3).
REQ-002 SHALL have parameter HIGH_LIM, default 13'sd480 (30.0 C), alarm set threshold, signed 1/16 C units.
REQ-003 SHALL have parameter LOW_LIM, default 13'sd448 (28.0 C), alarm clear threshold; LOW_LIM <= HIGH_LIM.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset; the block has one clock, and reset is synchronous and active-high.
REQ-006 sample_valid_i  input  1  one-cycle pulse marking a new temp_i sample (upstream sensor interrupt).
REQ-007 temp_i  input  13  two's-complement temperature, 1/16 C per LSB.
REQ-008 sign_o  output  1  1 = averaged temperature negative.
REQ-009 bcd_o  output  12  integer magnitude, BCD hundreds[11:8], tens[7:4], ones[3:0].
REQ-010 frac_o  output  4  tenths digit of magnitude, BCD, truncated.
REQ-011 valid_o  output  1  one-cycle pulse: sign_o/bcd_o/frac_o updated.
REQ-012 alarm_o  output  1  over-temperature level with hysteresis.
REQ-013 busy_o  output  1  high whenever FSM not in IDLE.
REQ-014 ovr_o  output  1  sticky: a sample was dropped.

Function
REQ-015 FSM states IDLE, ACCUM, AVG, CONV, DONE; IDLE->ACCUM when sample_valid_i=1 sampled in IDLE (temp_i captured same edge); ACCUM->AVG->CONV unconditionally; CONV lasts exactly 9 cycles; DONE->IDLE.
REQ-016 Latency: sample_valid_i sampled at edge k -> valid_o high during cycle following edge k+12, for exactly one cycle.
REQ-017 Circular buffer of 2^AVG_LOG2 13-bit entries plus signed running sum 13+AVG_LOG2 bits; ACCUM: sum <= sum - oldest + new, new overwrites oldest, write pointer wraps modulo depth.
REQ-018 First sample after reset: every buffer entry loaded with it, sum = sample << AVG_LOG2 (prefill); no partial-fill averaging.
REQ-019 AVG: avg = sum >>> AVG_LOG2 (arithmetic shift, floor); sign = avg[12]; mag = |avg| as 13-bit unsigned (-4096 -> 4096).
REQ-020 AVG: integer = mag[12:4] (0..256); tenths = (mag[3:0]*10) >> 4.
REQ-021 AVG: alarm_o <= 1 if avg >= HIGH_LIM; else alarm_o <= 0 if avg < LOW_LIM; else hold; signed compares.
REQ-022 CONV: double-dabble, 9 shift iterations of integer into 12-bit BCD, add-3 to any digit >= 5 before each shift.
REQ-023 DONE: sign_o, bcd_o, frac_o registered together, valid_o pulsed; outputs hold until next DONE.
REQ-024 sample_valid_i while busy_o=1 (including DONE cycle): sample ignored, buffer/sum untouched, ovr_o <= 1.
REQ-025 sample_valid_i held high multiple cycles: each cycle seen in IDLE starts a conversion; others count as drops.

Reset
REQ-026 rst_i high at a clock edge: FSM -> IDLE, sign_o=0, bcd_o=0, frac_o=0, valid_o=0, alarm_o=0, busy_o=0, ovr_o=0, sum=0, pointer=0, first-sample flag set; overrides any in-flight sample_valid_i.
REQ-027 Reset mid-conversion: conversion abandoned, no valid_o, next sample treated as first (prefill).

Verification
REQ-028 Reset, sample 13'h0190 (25.0 C) at edge k -> valid_o at k+12 only; sign_o=0, bcd_o=12'h025, frac_o=0, alarm_o=0, busy_o high k+1..k+12.
REQ-029 Fresh reset, sample 13'h1FF8 (-0.5 C) -> sign_o=1, bcd_o=12'h000, frac_o=5; fresh reset, sample 13'h1000 -> sign_o=1, bcd_o=12'h256, frac_o=0.
REQ-030 After prefill at 400, sample 480 -> avg 420 -> bcd_o=12'h026, frac_o=2; three more 480 -> final bcd_o=12'h030, frac_o=0, alarm_o=1.
REQ-031 Prefill 496 -> alarm_o=1; four samples 464 -> alarm_o stays 1; samples 432 -> avgs 456, 448, 440: alarm_o 1, 1, 0.
REQ-032 Samples at edges k and k+5 -> one valid_o at k+12, ovr_o=1 from k+5 on, buffer contains only first sample.
REQ-033 Sample at k, rst_i at k+6 -> no valid_o, all outputs 0; next sample 13'h0050 -> bcd_o=12'h005, frac_o=0 (prefill confirmed).
